// File: rtl/pipe_latch.sv
// Single pipeline-register stage with valid/ready handshake and synchronous flush.
// Define PIPE_LATCH_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_latch #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t out_q, out_n;
  logic   out_valid_q, out_valid_n;
  entry_t in_entry;
  logic   xfer_in;
  logic   xfer_out;

  assign in_entry  = '{instr: in_instr, pc: in_pc};
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_instr = out_q.instr;
  assign out_pc    = out_q.pc;

`ifdef PIPE_LATCH_SKID_EN

  entry_t skid_q, skid_n;
  logic   skid_valid_q, skid_valid_n;
  logic   in_ready_q;

  assign in_ready = in_ready_q;

  // State register; in_ready stays low through reset and rises on the first clock after it.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      out_valid_q  <= 1'b0;
      out_q        <= '{instr: NOP_WORD, pc: '0};
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_n;
      out_q        <= out_n;
      skid_valid_q <= skid_valid_n;
      skid_q       <= skid_n;
      in_ready_q   <= !skid_valid_n;
    end
  end

  // Next state: the skid only fills while the output is stalled and drains on the next pop.
  always_comb begin
    out_valid_n  = out_valid_q;
    out_n        = out_q;
    skid_valid_n = skid_valid_q;
    skid_n       = skid_q;
    if (flush) begin
      out_valid_n  = 1'b0;
      out_n.instr  = NOP_WORD;
      skid_valid_n = 1'b0;
    end else if (skid_valid_q) begin
      if (xfer_out) begin
        out_n        = skid_q;
        skid_valid_n = 1'b0;
      end
    end else if (out_valid_q && !out_ready) begin
      if (xfer_in) begin
        skid_n       = in_entry;
        skid_valid_n = 1'b1;
      end
    end else if (xfer_in) begin
      out_n       = in_entry;
      out_valid_n = 1'b1;
    end else if (xfer_out) begin
      out_valid_n = 1'b0;
      out_n.instr = NOP_WORD;
    end
  end

`else

  // Accept whenever the held entry is absent or leaving this cycle.
  assign in_ready = !out_valid_q || out_ready;

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      out_valid_q <= 1'b0;
      out_q       <= '{instr: NOP_WORD, pc: '0};
    end else begin
      out_valid_q <= out_valid_n;
      out_q       <= out_n;
    end
  end

  // Flush wins over a same-cycle load; a drained stage shows the bubble word but keeps its pc.
  always_comb begin
    out_valid_n = out_valid_q;
    out_n       = out_q;
    if (flush) begin
      out_valid_n = 1'b0;
      out_n.instr = NOP_WORD;
    end else if (xfer_in) begin
      out_n       = in_entry;
      out_valid_n = 1'b1;
    end else if (xfer_out) begin
      out_valid_n = 1'b0;
      out_n.instr = NOP_WORD;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_latch.sv
// Bench for pipe_latch: two instances (default and overridden bubble word) checked against a FIFO model.
module tb_pipe_latch;

  localparam logic [31:0] NOP0 = 32'h0000_0000;
  localparam logic [31:0] NOP1 = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [11:0] pc;
  } ent_t;

  logic        clock = 1'b0;
  logic        clr, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [11:0] in_pc;
  logic        rdy0, val0, rdy1, val1;
  logic [31:0] ins0, ins1;
  logic [11:0] pc0, pc1;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  logic [11:0] pc_m;
  bit   just_reset;

  always #5 clock = ~clock;

  pipe_latch u0 (
    .clock(clock), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(val0), .out_ready(out_ready), .out_instr(ins0), .out_pc(pc0)
  );

  pipe_latch #(.NOP_WORD(NOP1)) u1 (
    .clock(clock), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(val1), .out_ready(out_ready), .out_instr(ins1), .out_pc(pc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: capacity 1 with combinational ready, or capacity 2 with ready registered from occupancy.
  function automatic bit exp_ready();
`ifdef PIPE_LATCH_SKID_EN
    return !just_reset && (q.size() < 2);
`else
    return (q.size() == 0) || (out_ready === 1'b1);
`endif
  endfunction

  task automatic check_outputs();
    bit          v;
    bit          r;
    logic [31:0] e0, e1;
    v  = q.size() > 0;
    r  = exp_ready();
    e0 = v ? q[0].instr : NOP0;
    e1 = v ? q[0].instr : NOP1;
    chk("u0.out_valid", 32'(val0), 32'(v));
    chk("u0.out_instr", ins0, e0);
    chk("u0.out_pc", 32'(pc0), 32'(pc_m));
    chk("u0.in_ready", 32'(rdy0), 32'(r));
    chk("u1.out_valid", 32'(val1), 32'(v));
    chk("u1.out_instr", ins1, e1);
    chk("u1.out_pc", 32'(pc1), 32'(pc_m));
    chk("u1.in_ready", 32'(rdy1), 32'(r));
  endtask

  task automatic cycle(input bit iv, input bit fl, input bit ordy,
                       input logic [31:0] ins, input logic [11:0] pc);
    bit xin, xout;
    @(negedge clock);
    in_valid  = iv;
    flush     = fl;
    out_ready = ordy;
    in_instr  = ins;
    in_pc     = pc;
    #1;
    check_outputs();
    xin  = iv && exp_ready();
    xout = (q.size() > 0) && ordy;
    @(posedge clock);
    if (fl) begin
      q.delete();
    end else begin
      if (xout) void'(q.pop_front());
      if (xin) q.push_back('{instr: ins, pc: pc});
    end
    if (q.size() > 0) pc_m = q[0].pc;
    just_reset = 1'b0;
  endtask

  // Asynchronous clear pulse between clock edges; outputs must react with no edge.
  task automatic pulse_clr();
    @(negedge clock);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    clr      = 1'b1;
    #1;
    q.delete();
    pc_m       = '0;
    just_reset = 1'b1;
    check_outputs();
    #1;
    clr = 1'b0;
    @(posedge clock);
    just_reset = 1'b0;
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    pc_m = '0; just_reset = 1'b1;
    #1;
    check_outputs();
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    @(negedge clock);
    clr = 1'b0;
    #1;
    check_outputs();
    @(posedge clock);
    just_reset = 1'b0;

    // Streaming at full throughput
    cycle(1, 0, 1, 32'h11, 12'h001);
    cycle(1, 0, 1, 32'h22, 12'h002);
    cycle(1, 0, 1, 32'h33, 12'h003);
    cycle(0, 0, 1, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);

    // Stall four cycles with a competing offer, then drain
    cycle(1, 0, 1, 32'hAAAA_0001, 12'h004);
    repeat (4) cycle(1, 0, 0, 32'hBBBB_0002, 12'h008);
    cycle(0, 0, 1, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);

    // Flush beats a same-cycle load
    cycle(1, 0, 1, 32'h5555_0000, 12'h010);
    cycle(1, 1, 1, 32'h0000_DEAD, 12'h0DE);
    cycle(0, 0, 1, 32'h0, 12'h0);

    // Stall with offer, then two pops
    cycle(1, 0, 1, 32'h01, 12'h020);
    cycle(1, 0, 0, 32'h02, 12'h024);
    cycle(0, 0, 0, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);

    // Flush while full, then clear mid-stall and reload
    cycle(1, 0, 1, 32'h0A, 12'h030);
    cycle(1, 0, 0, 32'h0B, 12'h034);
    cycle(0, 1, 0, 32'h0, 12'h0);
    cycle(1, 0, 1, 32'h0C, 12'h038);
    cycle(1, 0, 0, 32'h0D, 12'h03C);
    pulse_clr();
    cycle(1, 0, 0, 32'h0E, 12'h040);
    cycle(1, 0, 1, 32'h0F, 12'h044);
    cycle(0, 0, 1, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);

    // Random traffic with occasional flush and clear
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        pulse_clr();
      end else begin
        cycle(bit'($urandom_range(0, 99) < 70),
              bit'($urandom_range(0, 99) < 4),
              bit'($urandom_range(0, 99) < 60),
              32'($urandom), 12'($urandom));
      end
    end
    cycle(0, 0, 1, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);
    cycle(0, 0, 1, 32'h0, 12'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
